multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle RV32 datapath; sits directly upstream of ALU_Control.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB for lw, sw, R-type and beq.
//  Drives the datapath enables and the 2-bit ALUOp (00 add, 01 sub, 10 funct-decoded).
//  Stalls on a memory-ready handshake, with an optional timeout watchdog.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles to wait for mem_ready in a memory state; 0 = wait forever
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  synchronous, active-high
//  Opcode       in   7  instr[6:0] from instruction register; valid from DECODE onward
//  mem_ready    in   1  memory completes the current access this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU Zero (beq)
//  IorD         out  1  mem addr select: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  instruction register load
//  MemtoReg     out  1  writeback select: 0=ALUOut, 1=MDR
//  RegWrite     out  1  register file write
//  ALUSrcA      out  1  0=PC, 1=reg A
//  ALUSrcB      out  2  00=reg B, 01=const 4, 10=immediate
//  ALUOp        out  2  to ALU_Control
//  PCSource     out  1  0=ALU result, 1=ALUOut
//  State        out  4  current state encoding (debug)
//  IllegalOp    out  1  sticky: unsupported opcode decoded
//  MemErr       out  1  sticky: memory timeout occurred
// BEHAVIOUR
//  - Clock and reset: reset is synchronous, active-high, on clk. On reset: State=FETCH(0),
//    wait counter=0, IllegalOp=0, MemErr=0.
//  - Output decoding: all outputs decode combinationally from State. PCWrite and IRWrite
//    are additionally gated by mem_ready in FETCH. Outputs not listed for a state are 0.
//  - Output values during reset: outputs follow the FETCH decode, with mem_ready gating.
//  - States 0..9:
//    FETCH   (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0;
//                 IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready, else stay.
//    DECODE  (1): ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
//                 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 1100011 -> BRANCH;
//                 0010011 -> EXECI when enabled; any other -> FETCH and set IllegalOp.
//    MEMADR  (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
//    MEMRD   (3): MemRead=1, IorD=1. Go to MEMWB on mem_ready.
//    MEMWB   (4): RegWrite=1, MemtoReg=1. Go to FETCH.
//    MEMWR   (5): MemWrite=1, IorD=1. Go to FETCH on mem_ready.
//    EXECR   (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
//    ALUWB   (7): RegWrite=1, MemtoReg=0. Go to FETCH.
//    BRANCH  (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Go to FETCH.
//    EXECI   (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 (addi only). Go to ALUWB.
//    Codes 10..15: go to FETCH.
//  - Latency per instruction, with zero memory wait: lw 5, sw 4, R 4, beq 3, addi 4 cycles.
//  - Wait counter, width $clog2(MEM_TIMEOUT+1):
//    counts cycles spent in FETCH/MEMRD/MEMWR with mem_ready=0; clears on every state change.
//  - Timeout: when the counter reaches MEM_TIMEOUT, go to FETCH, clear the counter and set
//    MemErr. In FETCH this restarts the fetch.
//  - Simultaneous: if mem_ready arrives in the timeout cycle, mem_ready wins and there is no error.
//  - Sticky flags: cleared only by reset.
//  - Reset mid-instruction: abort to FETCH next edge; no partial writeback occurs after reset.
// CONFIGURATION
//  RV_ITYPE_ADDI_EN defined: opcode 0010011 -> EXECI -> ALUWB. Immediate add, funct ignored.
//  RV_ITYPE_ADDI_EN undefined: EXECI does not exist; 0010011 is illegal (sets IllegalOp).
// STRUCTURE
//  Package mc_ctrl_pkg:
//    state localparams (4-bit); opcode constants (OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI);
//    ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
//    ALUSrcB encodings (SRCB_REG, SRCB_FOUR, SRCB_IMM).
//  Sub-module mc_mem_watchdog: wait counter and timeout pulse. All else is a single FSM.
// TESTING
//  - Reset held 2 cycles, mem_ready=1 -> State=0, MemRead=1, IRWrite=1, MemErr=0, IllegalOp=0.
//  - Opcode=0000011, mem_ready=1 always -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only
//    in state 4.
//  - Opcode=0110011 -> states 0,1,6,7,0. ALUOp=10 in state 6.
//    Opcode=1100011 -> states 0,1,8,0. ALUOp=01, PCWriteCond=1 in state 8.
//  - Opcode=0100011, mem_ready low 3 cycles in MEMWR -> stays in state 5 for 4 cycles,
//    MemWrite=1 throughout, then FETCH. MemErr stays 0.
//  - MEM_TIMEOUT=4, mem_ready=0 in MEMRD -> after 4 cycles State=0, MemErr=1.
//    Reset then clears MemErr.
//  - Opcode=0010011: without macro -> DECODE then FETCH, IllegalOp=1;
//    with RV_ITYPE_ADDI_EN -> states 0,1,9,7,0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants, control bundle type and output decode for the multicycle RV32 control FSM.
// EXECI decode is present only when RV_ITYPE_ADDI_EN is defined.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_EXECI  = 4'd9;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
  } ctrl_t;

  // A timeout of 0 means "wait forever"; keep a 1-bit saturating counter in that case.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic logic is_mem_state(input logic [3:0] state);
    return (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [3:0] state, input logic mem_ready);
    ctrl_t c;
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
`ifdef RV_ITYPE_ADDI_EN
      S_EXECI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory wait counter: counts stalled cycles in a memory state and pulses o_timeout
// on the cycle the count reaches MEM_TIMEOUT (never when MEM_TIMEOUT is 0).
module mc_mem_watchdog
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_state_change,
  output logic o_timeout
);

  localparam int CW = wait_cnt_w(MEM_TIMEOUT);
  localparam logic [CW:0] LIMIT = (CW + 1)'(MEM_TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_inc;
  logic          w_sat;

  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_sat     = &r_cnt;

  // The current stalled cycle counts, so the timeout fires in the MEM_TIMEOUT-th waiting cycle.
  assign o_timeout = (MEM_TIMEOUT != 0) && i_wait && (w_cnt_inc == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_state_change || o_timeout) begin
      r_cnt <= '0;
    end else if (i_wait && !w_sat) begin
      r_cnt <= w_cnt_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32 datapath (lw, sw, R-type, beq; addi when
// RV_ITYPE_ADDI_EN is defined), with mem_ready stalls and a memory timeout watchdog.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic [3:0] State,
  output logic       IllegalOp,
  output logic       MemErr
);

  logic [3:0] r_state;
  logic       r_illegal;
  logic       r_memerr;

  logic [3:0] w_next_fsm;
  logic [3:0] w_next;
  logic [3:0] w_dec_state;
  logic       w_illegal_dec;
  logic       w_wait;
  logic       w_timeout;
  logic       w_state_change;
  ctrl_t      w_ctrl;

  assign w_wait         = is_mem_state(r_state) && !mem_ready;
  assign w_next         = w_timeout ? S_FETCH : w_next_fsm;
  assign w_state_change = (w_next != r_state);

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk           (clk),
    .reset         (reset),
    .i_wait        (w_wait),
    .i_state_change(w_state_change),
    .o_timeout     (w_timeout)
  );

  always_comb begin
    w_next_fsm    = r_state;
    w_illegal_dec = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_fsm = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next_fsm = S_MEMADR;
          OP_R:         w_next_fsm = S_EXECR;
          OP_BEQ:       w_next_fsm = S_BRANCH;
`ifdef RV_ITYPE_ADDI_EN
          OP_ADDI:      w_next_fsm = S_EXECI;
`endif
          default: begin
            w_next_fsm    = S_FETCH;
            w_illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next_fsm = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next_fsm = S_MEMWB;
      S_MEMWB:  w_next_fsm = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next_fsm = S_FETCH;
      S_EXECR:  w_next_fsm = S_ALUWB;
      S_ALUWB:  w_next_fsm = S_FETCH;
      S_BRANCH: w_next_fsm = S_FETCH;
`ifdef RV_ITYPE_ADDI_EN
      S_EXECI:  w_next_fsm = S_ALUWB;
`endif
      default:  w_next_fsm = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_memerr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal_dec) r_illegal <= 1'b1;
      if (w_timeout)     r_memerr  <= 1'b1;
    end
  end

  // While reset is held the outputs show FETCH, so no write strobe from an aborted state leaks out.
  assign w_dec_state = reset ? S_FETCH : r_state;
  assign w_ctrl      = decode_ctrl(w_dec_state, mem_ready);

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign State       = w_dec_state;
  assign IllegalOp   = r_illegal;
  assign MemErr      = r_memerr;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized run
// against an instruction-path reference model (honours RV_ITYPE_ADDI_EN).
module tb_multicycle_control;

  localparam int TO = 4;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011, ADDI = 7'b0010011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, ALUSrcA, PCSource, IllegalOp, MemErr;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [13:0] act;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .IllegalOp(IllegalOp), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Expected control word per state, straight from the state table.
  function automatic logic [13:0] exp_ctrl(input int st, input logic mr);
    case (st)
      0: return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 3'b000, 2'b01, 2'b00, 1'b0};
      1: return {9'b0, 2'b10, 2'b00, 1'b0};
      2: return {8'b0, 1'b1, 2'b10, 2'b00, 1'b0};
      3: return {2'b00, 1'b1, 1'b1, 5'b0, 2'b00, 2'b00, 1'b0};
      4: return {6'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
      5: return {2'b00, 1'b1, 1'b0, 1'b1, 4'b0, 2'b00, 2'b00, 1'b0};
      6: return {8'b0, 1'b1, 2'b00, 2'b10, 1'b0};
      7: return {7'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
      8: return {1'b0, 1'b1, 6'b0, 1'b1, 2'b00, 2'b01, 1'b1};
      9: return {8'b0, 1'b1, 2'b10, 2'b00, 1'b0};
      default: return 14'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    Opcode = 7'd0;
    repeat (2) tick();
    n_checks++; if (State !== 4'd0) $display("FAIL reset_state got=%0d exp=0", State); else n_pass++;
    n_checks++; if (MemRead !== 1'b1) $display("FAIL reset_memread got=%b exp=1", MemRead); else n_pass++;
    n_checks++; if (IRWrite !== 1'b1) $display("FAIL reset_irwrite got=%b exp=1", IRWrite); else n_pass++;
    n_checks++; if (MemErr !== 1'b0) $display("FAIL reset_memerr got=%b exp=0", MemErr); else n_pass++;
    n_checks++; if (IllegalOp !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", IllegalOp); else n_pass++;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_lw();
    int seq[] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    Opcode = LW;
    for (int i = 0; i < seq.size(); i++) begin
      n_checks++;
      if (State !== 4'(seq[i])) $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, State, seq[i]);
      else n_pass++;
      n_checks++;
      if ({RegWrite, MemtoReg} !== {2{seq[i] == 4}})
        $display("FAIL lw_wb step=%0d got=%b exp=%b", i, {RegWrite, MemtoReg}, {2{seq[i] == 4}});
      else n_pass++;
      if (i < seq.size() - 1) tick();
    end
  endtask

  task automatic test_r_beq();
    int rseq[] = '{0, 1, 6, 7, 0};
    int bseq[] = '{0, 1, 8, 0};
    do_reset();
    Opcode = RT;
    for (int i = 0; i < rseq.size(); i++) begin
      n_checks++;
      if (State !== 4'(rseq[i])) $display("FAIL r_state step=%0d got=%0d exp=%0d", i, State, rseq[i]);
      else n_pass++;
      if (rseq[i] == 6) begin
        n_checks++;
        if (ALUOp !== 2'b10) $display("FAIL r_aluop got=%b exp=10", ALUOp); else n_pass++;
      end
      if (i < rseq.size() - 1) tick();
    end
    Opcode = BEQ;
    for (int i = 0; i < bseq.size(); i++) begin
      n_checks++;
      if (State !== 4'(bseq[i])) $display("FAIL beq_state step=%0d got=%0d exp=%0d", i, State, bseq[i]);
      else n_pass++;
      if (bseq[i] == 8) begin
        n_checks++;
        if ({ALUOp, PCWriteCond} !== 3'b011)
          $display("FAIL beq_ctrl got=%b exp=011", {ALUOp, PCWriteCond});
        else n_pass++;
      end
      if (i < bseq.size() - 1) tick();
    end
  endtask

  task automatic test_sw_stall();
    do_reset();
    Opcode = SW;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      n_checks++;
      if ({State, MemWrite} !== {4'd5, 1'b1})
        $display("FAIL sw_stall cyc=%0d got state=%0d mw=%b exp state=5 mw=1", i, State, MemWrite);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (State !== 4'd0) $display("FAIL sw_done_state got=%0d exp=0", State); else n_pass++;
    n_checks++; if (MemErr !== 1'b0) $display("FAIL sw_memerr got=%b exp=0", MemErr); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    Opcode = LW;
    repeat (3) tick();
    mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      n_checks++;
      if ({State, MemErr} !== {4'd3, 1'b0})
        $display("FAIL to_wait cyc=%0d got state=%0d err=%b exp state=3 err=0", i, State, MemErr);
      else n_pass++;
      tick();
    end
    n_checks++; if (State !== 4'd0) $display("FAIL to_state got=%0d exp=0", State); else n_pass++;
    n_checks++; if (MemErr !== 1'b1) $display("FAIL to_memerr got=%b exp=1", MemErr); else n_pass++;
    do_reset();
    n_checks++; if (MemErr !== 1'b0) $display("FAIL to_clear got=%b exp=0", MemErr); else n_pass++;
  endtask

  task automatic test_addi();
`ifdef RV_ITYPE_ADDI_EN
    int seq[] = '{0, 1, 9, 7, 0};
    logic exp_ill = 1'b0;
`else
    int seq[] = '{0, 1, 0};
    logic exp_ill = 1'b1;
`endif
    do_reset();
    Opcode = ADDI;
    for (int i = 0; i < seq.size(); i++) begin
      n_checks++;
      if (State !== 4'(seq[i])) $display("FAIL addi_state step=%0d got=%0d exp=%0d", i, State, seq[i]);
      else n_pass++;
      if (i < seq.size() - 1) tick();
    end
    n_checks++;
    if (IllegalOp !== exp_ill) $display("FAIL addi_illegal got=%b exp=%b", IllegalOp, exp_ill);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    Opcode = LW;
    repeat (4) tick();
    n_checks++; if (State !== 4'd4) $display("FAIL mid_pre got=%0d exp=4", State); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({State, RegWrite} !== {4'd0, 1'b0})
      $display("FAIL mid_reset got state=%0d rw=%b exp state=0 rw=0", State, RegWrite);
    else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({State, RegWrite} !== {4'd0, 1'b0})
      $display("FAIL mid_after got state=%0d rw=%b exp state=0 rw=0", State, RegWrite);
    else n_pass++;
  endtask

  // Reference model: each opcode maps to its list of visited states; memory states
  // hold until mem_ready or the TO-th stalled cycle, which aborts back to FETCH.
  int   m_path[$];
  logic m_path_ill;

  task automatic set_path(input logic [6:0] op);
    m_path_ill = 1'b0;
    case (op)
      LW:  m_path = '{0, 1, 2, 3, 4};
      SW:  m_path = '{0, 1, 2, 5};
      RT:  m_path = '{0, 1, 6, 7};
      BEQ: m_path = '{0, 1, 8};
`ifdef RV_ITYPE_ADDI_EN
      ADDI: m_path = '{0, 1, 9, 7};
`endif
      default: begin m_path = '{0, 1}; m_path_ill = 1'b1; end
    endcase
  endtask

  task automatic test_random();
    int   idx = 0, waits = 0, st;
    logic need_new = 1'b1, m_err = 1'b0, m_ill = 1'b0;
    logic [6:0] op;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (need_new) begin
        case ($urandom_range(0, 5))
          0: op = LW;
          1: op = SW;
          2: op = RT;
          3: op = BEQ;
          4: op = ADDI;
          default: op = 7'($urandom);
        endcase
        set_path(op);
        Opcode = op;
        idx = 0;
        need_new = 1'b0;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      #1;
      st = m_path[idx];
      n_checks++;
      if (State !== 4'(st)) $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, State, st);
      else n_pass++;
      n_checks++;
      if (act !== exp_ctrl(st, mem_ready))
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, act, exp_ctrl(st, mem_ready));
      else n_pass++;
      n_checks++;
      if ({IllegalOp, MemErr} !== {m_ill, m_err})
        $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {IllegalOp, MemErr}, {m_ill, m_err});
      else n_pass++;
      if (st == 0 || st == 3 || st == 5) begin
        if (mem_ready) begin
          idx++;
          waits = 0;
        end else begin
          waits++;
          if (waits == TO) begin
            m_err = 1'b1;
            waits = 0;
            idx = 0;
          end
        end
      end else begin
        if (st == 1 && m_path_ill) m_ill = 1'b1;
        idx++;
      end
      if (idx >= m_path.size()) need_new = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_r_beq();
    test_sw_stall();
    test_timeout();
    test_addi();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
